rx_crc_chk: RTL and testbench
=============================

# rx_crc_chk

Parametrised receive-side CRC checker: accepts one frame word (message bits followed by received CRC bits) per valid/ready handshake, performs modulo-2 division by a configurable generator at BITS_PER_CYC bits per clock, and returns the remainder plus a pass/fail flag over an output handshake. It sits between the deserialiser's frame aligner and the link-layer receive logic. It replaces the fixed-width, one-bit-per-cycle checker, adding back-pressure, flush and a selectable processing rate.

## Interface
- CRC_W, 8: CRC width; generator is {1'b1, POLY}.
- DATA_W, 32: message bits per frame; must be ≥ CRC_W.
- POLY, 8'h07: generator low CRC_W bits (implicit x^CRC_W term).
- BITS_PER_CYC, 1: division steps per clock; must divide DATA_W.
- SEED, {CRC_W{1'b0}}: initial-value mask; used only with RX_CRC_CHK_SEED_EN.

- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort; discards frame in progress.
- in_vld  input  1  frame word valid.
- in_rdy  output  1  checker can accept a frame.
- in_data  input  DATA_W+CRC_W  frame, MSB first: {message, received_crc}.
- out_vld  output  1  result valid.
- out_rdy  input  1  consumer accepts result.
- out_rem  output  CRC_W  division remainder.
- out_err  output  1  |out_rem (1 = CRC mismatch).
- busy  output  1  state != IDLE.

## Operation
- States IDLE, CALC, DONE. Reset → IDLE; all outputs 0 except in_rdy = 1 (after reset deasserts; rst forces in_rdy = 0).
- in_rdy = (state == IDLE) & !flush. Accept when in_vld & in_rdy.
- Load: rem ← in_data[top CRC_W bits] (XOR SEED if enabled); shift register ← remaining DATA_W bits; cnt ← 0; → CALC.
- Division step: msb = rem[CRC_W-1]; rem ← {rem[CRC_W-2:0], next_bit} ^ (msb ? POLY : 0); shift register shifts left, zero fill. BITS_PER_CYC steps chained combinationally per clock.
- CALC: cnt increments each clock; after N = DATA_W/BITS_PER_CYC clocks → DONE. cnt width $clog2(N+1).
- DONE: out_vld = 1, out_rem/out_err held stable; on out_vld & out_rdy → IDLE. No new frame accepted in the handshake cycle.
- flush in any state: → IDLE next edge, out_vld drops, rem/shift register/cnt cleared. flush beats in_vld and out_rdy in the same cycle.
- rst mid-operation: immediate return to IDLE, frame lost, no out_vld.
- in_data sampled only at acceptance; changes during CALC have no effect.

## Timing
- Acceptance at edge t; out_vld rises after edge t+N; latency N clocks (DATA_W=32, BPC=1 → 32; BPC=8 → 4).
- out_rdy held high: DONE lasts one cycle; in_rdy returns after edge t+N+1. Throughput one frame per N+2 clocks.
- out_rdy low: out_vld and results hold indefinitely; in_rdy stays 0.
- out_err is registered with out_rem; no combinational path from inputs to out_vld/out_rem/out_err. in_rdy has a combinational path from flush only.

## Configuration
- RX_CRC_CHK_SEED_EN defined: SEED XORed into the first CRC_W frame bits at load (non-zero-init CRC variants).
- Undefined: SEED ignored, initial value 0; load path has no XOR.

## Structure
- Shared package rx_crc_pkg: state encoding (IDLE/CALC/DONE), default CRC_W/DATA_W/POLY constants, cnt-width helper.
- Sub-module crc_div_step: combinational, parametrised CRC_W/POLY/BITS_PER_CYC; takes rem and next BITS_PER_CYC data bits, returns updated rem. Top holds FSM, counter, registers, handshakes.

## Test plan
- CRC_W=8, DATA_W=8, POLY=07, BPC=1: in_data=16'h3197 → out_vld 8 clocks after accept, out_rem=8'h00, out_err=0.
- Same config, in_data=16'h3196 → out_rem=8'h01, out_err=1.
- BPC=4, in_data=16'h3197 → out_vld 2 clocks after accept, out_rem=8'h00; in_vld asserted during CALC → in_rdy=0, second frame accepted only after output handshake.
- out_rdy low for 5 cycles after out_vld → out_rem/out_err stable, in_rdy=0; out_rdy high → IDLE next edge.
- flush at cycle 3 of CALC, then frame 16'h3196 → no output for first frame; second yields out_rem=8'h01. Repeat with rst pulse mid-CALC → all outputs 0.
- RX_CRC_CHK_SEED_EN, SEED=8'hFF, in_data=16'h0000 → out_rem=8'hF3, out_err=1; without macro same stimulus → out_rem=8'h00.

Source files
------------

// File: rtl/rx_crc_pkg.sv
// Shared definitions for the receive CRC checker: FSM encoding, default
// geometry and the frame counter width helper.
package rx_crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int         DEF_CRC_W  = 8;
    localparam int         DEF_DATA_W = 32;
    localparam logic [7:0] DEF_POLY   = 8'h07;

    // Counter must be able to hold the step count itself, not just N-1.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/crc_div_step.sv
// Combinational modulo-2 division slice: BITS_PER_CYC chained shift/XOR
// steps of the running remainder by the generator {1'b1, POLY}.
module crc_div_step #(
    parameter int               CRC_W        = 8,
    parameter logic [CRC_W-1:0] POLY         = 8'h07,
    parameter int               BITS_PER_CYC = 1
) (
    input  logic [CRC_W-1:0]        rem_in,
    input  logic [BITS_PER_CYC-1:0] bits_in,
    output logic [CRC_W-1:0]        rem_out
);

    logic [CRC_W-1:0] rem_acc;
    logic             msb;

    always_comb begin
        rem_acc = rem_in;
        msb     = 1'b0;
        // bits_in is MSB first: the highest bit enters the remainder first.
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            msb     = rem_acc[CRC_W-1];
            rem_acc = {rem_acc[CRC_W-2:0], bits_in[BITS_PER_CYC-1-i]} ^ (msb ? POLY : '0);
        end
        rem_out = rem_acc;
    end

endmodule

// File: rtl/rx_crc_chk.sv
// Receive-side CRC checker: divides {message, received_crc} by the generator
// and reports the remainder. Optional seed mask on load: RX_CRC_CHK_SEED_EN.
module rx_crc_chk
    import rx_crc_pkg::*;
#(
    parameter int               CRC_W        = DEF_CRC_W,
    parameter int               DATA_W       = DEF_DATA_W,
    parameter logic [CRC_W-1:0] POLY         = CRC_W'(DEF_POLY),
    parameter int               BITS_PER_CYC = 1,
    parameter logic [CRC_W-1:0] SEED         = {CRC_W{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [DATA_W+CRC_W-1:0] in_data,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [CRC_W-1:0]        out_rem,
    output logic                    out_err,
    output logic                    busy
);

    localparam int               N        = DATA_W / BITS_PER_CYC;
    localparam int               CNT_W    = cnt_width(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

`ifdef RX_CRC_CHK_SEED_EN
    localparam logic [CRC_W-1:0] LOAD_MASK = SEED;
`else
    // Seed disabled: mask folds to zero so the load path is a plain wire.
    localparam logic [CRC_W-1:0] LOAD_MASK = SEED & {CRC_W{1'b0}};
`endif

    state_t            state_q, state_d;
    logic [CRC_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_vld_q, out_vld_d;
    logic [CRC_W-1:0]  out_rem_q, out_rem_d;
    logic              out_err_q, out_err_d;
    logic [CRC_W-1:0]  rem_step;

    crc_div_step #(
        .CRC_W        (CRC_W),
        .POLY         (POLY),
        .BITS_PER_CYC (BITS_PER_CYC)
    ) u_step (
        .rem_in  (rem_q),
        .bits_in (sh_q[DATA_W-1 -: BITS_PER_CYC]),
        .rem_out (rem_step)
    );

    assign in_rdy  = (state_q == ST_IDLE) && !flush && !rst;
    assign busy    = (state_q != ST_IDLE);
    assign out_vld = out_vld_q;
    assign out_rem = out_rem_q;
    assign out_err = out_err_q;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        out_vld_d = out_vld_q;
        out_rem_d = out_rem_q;
        out_err_d = out_err_q;
        if (flush) begin
            state_d   = ST_IDLE;
            rem_d     = '0;
            sh_d      = '0;
            cnt_d     = '0;
            out_vld_d = 1'b0;
            out_rem_d = '0;
            out_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_vld && in_rdy) begin
                        state_d = ST_CALC;
                        rem_d   = in_data[DATA_W+CRC_W-1 -: CRC_W] ^ LOAD_MASK;
                        sh_d    = in_data[DATA_W-1:0];
                        cnt_d   = '0;
                    end
                end
                ST_CALC: begin
                    rem_d = rem_step;
                    sh_d  = sh_q << BITS_PER_CYC;
                    cnt_d = cnt_q + CNT_W'(1);
                    // Result registers capture the final step directly.
                    if (cnt_q == CNT_LAST) begin
                        state_d   = ST_DONE;
                        out_vld_d = 1'b1;
                        out_rem_d = rem_step;
                        out_err_d = |rem_step;
                    end
                end
                ST_DONE: begin
                    if (out_rdy) begin
                        state_d   = ST_IDLE;
                        out_vld_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            sh_q      <= '0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            out_rem_q <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            out_vld_q <= out_vld_d;
            out_rem_q <= out_rem_d;
            out_err_q <= out_err_d;
        end
    end

endmodule

// File: tb/tb_rx_crc_chk.sv
// Scoreboard bench for rx_crc_chk: one instance at 1 bit/clock, one at 4.
module tb_rx_crc_chk;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush   [2];
    logic       in_vld  [2];
    logic       in_rdy  [2];
    logic [15:0] in_data[2];
    logic       out_vld [2];
    logic       out_rdy [2];
    logic [7:0] out_rem [2];
    logic       out_err [2];
    logic       busy    [2];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] rem;
        int         acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e_m;
    logic pv[2];
    int   vc[2];
    int   last_acc[2];

`ifdef RX_CRC_CHK_SEED_EN
    localparam logic [7:0] SEED_EXP = 8'hF3;
`else
    localparam logic [7:0] SEED_EXP = 8'h00;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rx_crc_chk #(.CRC_W(8), .DATA_W(8), .POLY(8'h07), .BITS_PER_CYC(1), .SEED(8'hFF)) dut1 (
        .clk(clk), .rst(rst), .flush(flush[0]), .in_vld(in_vld[0]), .in_rdy(in_rdy[0]),
        .in_data(in_data[0]), .out_vld(out_vld[0]), .out_rdy(out_rdy[0]),
        .out_rem(out_rem[0]), .out_err(out_err[0]), .busy(busy[0]));

    rx_crc_chk #(.CRC_W(8), .DATA_W(8), .POLY(8'h07), .BITS_PER_CYC(4), .SEED(8'hFF)) dut4 (
        .clk(clk), .rst(rst), .flush(flush[1]), .in_vld(in_vld[1]), .in_rdy(in_rdy[1]),
        .in_data(in_data[1]), .out_vld(out_vld[1]), .out_rdy(out_rdy[1]),
        .out_rem(out_rem[1]), .out_err(out_err[1]), .busy(busy[1]));

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] er);
        n_chk++;
        if (act !== er) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, er, cyc);
        end
    endfunction

    function automatic int q_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t q_front(input int i);
        if (i == 0) return q0[0];
        return q1[0];
    endfunction

    function automatic void q_pop(input int i);
        if (i == 0) q0.delete(0);
        else q1.delete(0);
    endfunction

    // Monitor: every cycle a result is presented it must match the queue head.
    always begin
        @(negedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            if (out_vld[i] && !pv[i]) vc[i] = cyc;
            if (out_vld[i]) begin
                if (q_size(i) == 0) begin
                    chk("unexpected_out", {31'b0, out_vld[i]}, 32'd0);
                end else begin
                    e_m = q_front(i);
                    chk("out_rem", {24'b0, out_rem[i]}, {24'b0, e_m.rem});
                    chk("out_err", {31'b0, out_err[i]}, {31'b0, |e_m.rem});
                    if (out_rdy[i]) begin
                        chk("latency", vc[i] - e_m.acc, (i == 0) ? 8 : 2);
                        q_pop(i);
                    end
                end
            end
            pv[i] = out_vld[i];
        end
    end

    task automatic send(input int i, input logic [15:0] d, input bit track, input logic [7:0] er);
        int n = 0;
        @(negedge clk);
        in_vld[i]  = 1'b1;
        in_data[i] = d;
        #1;
        while (!in_rdy[i] && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            chk("accept_timeout", {31'b0, in_rdy[i]}, 32'd1);
        end else begin
            @(posedge clk);
            #1;
            last_acc[i] = cyc;
            if (track) begin
                if (i == 0) q0.push_back('{rem: er, acc: cyc});
                else q1.push_back('{rem: er, acc: cyc});
            end
            in_vld[i]  = 1'b0;
            in_data[i] = ~d;
        end
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while ((busy[i] || q_size(i) != 0) && n < 200);
        if (n >= 200) chk("idle_timeout", {31'b0, busy[i]}, 32'd0);
    endtask

    task automatic chk_all_zero(input int i, input string nm);
        chk({nm, "_in_rdy"},  {31'b0, in_rdy[i]},  32'd0);
        chk({nm, "_out_vld"}, {31'b0, out_vld[i]}, 32'd0);
        chk({nm, "_out_rem"}, {24'b0, out_rem[i]}, 32'd0);
        chk({nm, "_out_err"}, {31'b0, out_err[i]}, 32'd0);
        chk({nm, "_busy"},    {31'b0, busy[i]},    32'd0);
    endtask

    initial begin
        int acc_a;
        int hs;
        int n;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            flush[i] = 1'b0; in_vld[i] = 1'b0; in_data[i] = '0; out_rdy[i] = 1'b1;
            pv[i] = 1'b0; vc[i] = 0; last_acc[i] = 0;
        end
        @(negedge clk);
        #1;
        chk_all_zero(0, "reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rdy_after_reset0", {31'b0, in_rdy[0]}, 32'd1);
        chk("rdy_after_reset1", {31'b0, in_rdy[1]}, 32'd1);

        // Good and corrupted frames at 1 bit/clock.
        send(0, 16'h3197, 1'b1, 8'h00);
        wait_idle(0);
        send(0, 16'h3196, 1'b1, 8'h01);
        wait_idle(0);

        // Back-to-back frames: one frame per N+2 clocks.
        send(0, 16'h0107, 1'b1, 8'h00);
        acc_a = last_acc[0];
        send(0, 16'hFFF2, 1'b1, 8'h01);
        chk("throughput", last_acc[0] - acc_a, 32'd10);
        wait_idle(0);

        send(0, 16'h0000, 1'b1, SEED_EXP);
        wait_idle(0);

        // flush gates in_rdy combinationally while idle.
        @(negedge clk);
        flush[0] = 1'b1;
        #1;
        chk("rdy_during_flush", {31'b0, in_rdy[0]}, 32'd0);
        @(negedge clk);
        flush[0] = 1'b0;
        #1;
        chk("rdy_after_flush", {31'b0, in_rdy[0]}, 32'd1);

        // Abort a frame mid-calculation with flush; it must never report.
        send(0, 16'h3197, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        flush[0] = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0;
        #1;
        chk("flush_busy", {31'b0, busy[0]}, 32'd0);
        chk("flush_vld", {31'b0, out_vld[0]}, 32'd0);
        send(0, 16'h3196, 1'b1, 8'h01);
        wait_idle(0);

        // Reset pulse mid-calculation.
        send(0, 16'h3196, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero(0, "rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        send(0, 16'h3197, 1'b1, 8'h00);
        wait_idle(0);

        // 4 bits/clock with back-pressure and a queued second frame.
        out_rdy[1] = 1'b0;
        send(1, 16'h3197, 1'b1, 8'h00);
        in_vld[1]  = 1'b1;
        in_data[1] = 16'h3196;
        @(negedge clk);
        #1;
        chk("rdy_in_calc", {31'b0, in_rdy[1]}, 32'd0);
        n = 0;
        while (!out_vld[1] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("bp_vld_seen", {31'b0, out_vld[1]}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("bp_vld_hold", {31'b0, out_vld[1]}, 32'd1);
            chk("bp_rdy_low", {31'b0, in_rdy[1]}, 32'd0);
        end
        @(negedge clk);
        out_rdy[1] = 1'b1;
        hs = cyc;
        send(1, 16'h3196, 1'b1, 8'h01);
        chk("second_accept", last_acc[1] - hs, 32'd2);
        wait_idle(1);

        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
